// File: rtl/fabric_rx_forwarder.sv
`default_nettype none
// ============================================================================
// Module      : fabric_rx_forwarder
// Description : Fabric-side consumer of one port's RX FIFO. Looks up the head
//               frame's destination set, requests the egress crossbar and
//               streams the frame's 64-bit blocks once granted. Frames with no
//               destination, a lookup timeout or zero length are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module fabric_rx_forwarder #(
  parameter int NUM_PORTS      = 14,
  parameter int SRC_PORT       = 0,
  parameter int LOOKUP_TIMEOUT = 255
) (
  input  logic                 fabric_clk,
  input  logic                 fabric_reset,
  // RX FIFO head-of-line frame status
  input  logic                 rx_frame_valid,
  input  logic [47:0]          rx_frame_dst_mac,
  input  logic [11:0]          rx_frame_vlan,
  input  logic [10:0]          rx_frame_len,
  // RX FIFO readout
  output logic                 rx_fwd_en,
  input  logic                 rx_fwd_valid,
  input  logic [3:0]           rx_fwd_bytes_valid,
  input  logic [63:0]          rx_fwd_data,
  output logic                 rx_pop,
  // Forwarding-table lookup
  output logic                 lookup_en,
  output logic [47:0]          lookup_dst_mac,
  output logic [11:0]          lookup_vlan,
  input  logic                 lookup_done,
  input  logic [NUM_PORTS-1:0] lookup_port_mask,
  // Egress crossbar
  output logic                 xbar_req,
  output logic [NUM_PORTS-1:0] xbar_port_mask,
  input  logic                 xbar_grant,
  output logic                 xbar_valid,
  output logic                 xbar_start,
  output logic                 xbar_last,
  output logic [3:0]           xbar_bytes_valid,
  output logic [63:0]          xbar_data,
  // Statistics pulses
  output logic                 fwd_count,
  output logic                 drop_count
);

  localparam int                   c_TMR_W    = (LOOKUP_TIMEOUT < 1) ? 1 : $clog2(LOOKUP_TIMEOUT + 1);
  localparam logic [c_TMR_W-1:0]   c_TIMEOUT  = c_TMR_W'(LOOKUP_TIMEOUT);
  localparam logic [NUM_PORTS-1:0] c_SRC_BIT  = NUM_PORTS'(1) << SRC_PORT;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_ARB    = 3'd2,
    S_FWD    = 3'd3,
    S_POP    = 3'd4,
    S_DROP   = 3'd5,
    S_HOLD   = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [47:0]            r_dst_mac;
  logic [11:0]            r_vlan;
  logic [10:0]            r_len;
  logic [NUM_PORTS-1:0]   r_mask;
  logic [8:0]             r_beats;
  logic [8:0]             r_beat_cnt;
  logic [c_TMR_W-1:0]     r_timer;

  logic                   r_lookup_en;
  logic                   r_xbar_req;
  logic                   r_rx_fwd_en;
  logic                   r_rx_pop;
  logic                   r_fwd_count;
  logic                   r_drop_count;
  logic                   r_xbar_valid;
  logic                   r_xbar_start;
  logic                   r_xbar_last;
  logic [3:0]             r_xbar_bytes;
  logic [63:0]            r_xbar_data;

  logic [NUM_PORTS-1:0]   w_lookup_mask;
  logic [8:0]             w_beats;
  logic                   w_beat_in;
  logic                   w_beat_is_last;

  // Own port is never a legal destination for a frame received on it.
  assign w_lookup_mask  = lookup_port_mask & ~c_SRC_BIT;
  // Number of 64-bit blocks, rounding a partial final block up (1..256).
  assign w_beats        = 9'(({1'b0, r_len} + 12'd7) >> 3);
  assign w_beat_in      = (r_state == S_FWD) && rx_fwd_valid;
  assign w_beat_is_last = (r_beat_cnt + 9'd1) == r_beats;

  // Next-state decode for the frame sequencing FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_frame_valid) begin
          w_next = (rx_frame_len == 11'd0) ? S_DROP : S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        // A result arriving on the timeout cycle still wins.
        if (lookup_done) begin
          w_next = (w_lookup_mask == '0) ? S_DROP : S_ARB;
        end else if (r_timer == c_TIMEOUT) begin
          w_next = S_DROP;
        end
      end
      S_ARB: begin
        if (xbar_grant) begin
          w_next = S_FWD;
        end
      end
      S_FWD: begin
        if (w_beat_in && w_beat_is_last) begin
          w_next = S_POP;
        end
      end
      S_POP:   w_next = S_HOLD;
      S_DROP:  w_next = S_HOLD;
      S_HOLD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge fabric_clk or posedge fabric_reset) begin
    if (fabric_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Per-frame context: lookup key, length, destination mask and beat budget.
  always_ff @(posedge fabric_clk or posedge fabric_reset) begin
    if (fabric_reset) begin
      r_dst_mac  <= '0;
      r_vlan     <= '0;
      r_len      <= '0;
      r_mask     <= '0;
      r_beats    <= '0;
      r_beat_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && rx_frame_valid) begin
        r_dst_mac <= rx_frame_dst_mac;
        r_vlan    <= rx_frame_vlan;
        r_len     <= rx_frame_len;
      end
      if ((r_state == S_LOOKUP) && lookup_done) begin
        r_mask <= w_lookup_mask;
      end else if ((r_state == S_ARB) && xbar_grant) begin
        r_mask <= '0;
      end
      if ((r_state == S_ARB) && xbar_grant) begin
        r_beats    <= w_beats;
        r_beat_cnt <= '0;
      end else if (w_beat_in) begin
        r_beat_cnt <= r_beat_cnt + 9'd1;
      end
    end
  end

  // Lookup timeout counter: counts cycles since lookup_en, idle elsewhere.
  always_ff @(posedge fabric_clk or posedge fabric_reset) begin
    if (fabric_reset) begin
      r_timer <= '0;
    end else if (r_state == S_LOOKUP) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  // Control pulses and crossbar request, registered off the next state.
  always_ff @(posedge fabric_clk or posedge fabric_reset) begin
    if (fabric_reset) begin
      r_lookup_en  <= 1'b0;
      r_xbar_req   <= 1'b0;
      r_rx_fwd_en  <= 1'b0;
      r_rx_pop     <= 1'b0;
      r_fwd_count  <= 1'b0;
      r_drop_count <= 1'b0;
    end else begin
      r_lookup_en  <= (r_state == S_IDLE) && (w_next == S_LOOKUP);
      r_xbar_req   <= (w_next == S_ARB);
      r_rx_fwd_en  <= (r_state == S_ARB) && xbar_grant;
      r_rx_pop     <= (w_next == S_POP) || (w_next == S_DROP);
      r_fwd_count  <= (w_next == S_POP);
      r_drop_count <= (w_next == S_DROP);
    end
  end

  // Egress datapath: one-cycle registered pass-through of FIFO beats in FWD.
  always_ff @(posedge fabric_clk or posedge fabric_reset) begin
    if (fabric_reset) begin
      r_xbar_valid <= 1'b0;
      r_xbar_start <= 1'b0;
      r_xbar_last  <= 1'b0;
      r_xbar_bytes <= '0;
      r_xbar_data  <= '0;
    end else begin
      r_xbar_valid <= w_beat_in;
      r_xbar_start <= w_beat_in && (r_beat_cnt == 9'd0);
      r_xbar_last  <= w_beat_in && w_beat_is_last;
      if (w_beat_in) begin
        r_xbar_bytes <= rx_fwd_bytes_valid;
        r_xbar_data  <= rx_fwd_data;
      end
    end
  end

  assign lookup_en        = r_lookup_en;
  assign lookup_dst_mac   = r_dst_mac;
  assign lookup_vlan      = r_vlan;
  assign xbar_req         = r_xbar_req;
  assign xbar_port_mask   = r_mask;
  assign rx_fwd_en        = r_rx_fwd_en;
  assign rx_pop           = r_rx_pop;
  assign fwd_count        = r_fwd_count;
  assign drop_count       = r_drop_count;
  assign xbar_valid       = r_xbar_valid;
  assign xbar_start       = r_xbar_start;
  assign xbar_last        = r_xbar_last;
  assign xbar_bytes_valid = r_xbar_bytes;
  assign xbar_data        = r_xbar_data;

endmodule
`default_nettype wire

// File: tb/tb_fabric_rx_forwarder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fabric_rx_forwarder
// Description : Directed self-checking bench for fabric_rx_forwarder. Acts as
//               RX FIFO, lookup engine and crossbar arbiter; a negedge monitor
//               collects egress beats and event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_rx_forwarder;

  localparam int c_NUM_PORTS = 14;
  localparam int c_TIMEOUT   = 20;
  localparam int c_WAIT_MAX  = 400;

  logic                   fabric_clk = 1'b0;
  logic                   fabric_reset;
  logic                   rx_frame_valid;
  logic [47:0]            rx_frame_dst_mac;
  logic [11:0]            rx_frame_vlan;
  logic [10:0]            rx_frame_len;
  logic                   rx_fwd_en;
  logic                   rx_fwd_valid;
  logic [3:0]             rx_fwd_bytes_valid;
  logic [63:0]            rx_fwd_data;
  logic                   rx_pop;
  logic                   lookup_en;
  logic [47:0]            lookup_dst_mac;
  logic [11:0]            lookup_vlan;
  logic                   lookup_done;
  logic [c_NUM_PORTS-1:0] lookup_port_mask;
  logic                   xbar_req;
  logic [c_NUM_PORTS-1:0] xbar_port_mask;
  logic                   xbar_grant;
  logic                   xbar_valid;
  logic                   xbar_start;
  logic                   xbar_last;
  logic [3:0]             xbar_bytes_valid;
  logic [63:0]            xbar_data;
  logic                   fwd_count;
  logic                   drop_count;

  fabric_rx_forwarder #(
    .NUM_PORTS      (c_NUM_PORTS),
    .SRC_PORT       (0),
    .LOOKUP_TIMEOUT (c_TIMEOUT)
  ) u_dut (
    .fabric_clk         (fabric_clk),
    .fabric_reset       (fabric_reset),
    .rx_frame_valid     (rx_frame_valid),
    .rx_frame_dst_mac   (rx_frame_dst_mac),
    .rx_frame_vlan      (rx_frame_vlan),
    .rx_frame_len       (rx_frame_len),
    .rx_fwd_en          (rx_fwd_en),
    .rx_fwd_valid       (rx_fwd_valid),
    .rx_fwd_bytes_valid (rx_fwd_bytes_valid),
    .rx_fwd_data        (rx_fwd_data),
    .rx_pop             (rx_pop),
    .lookup_en          (lookup_en),
    .lookup_dst_mac     (lookup_dst_mac),
    .lookup_vlan        (lookup_vlan),
    .lookup_done        (lookup_done),
    .lookup_port_mask   (lookup_port_mask),
    .xbar_req           (xbar_req),
    .xbar_port_mask     (xbar_port_mask),
    .xbar_grant         (xbar_grant),
    .xbar_valid         (xbar_valid),
    .xbar_start         (xbar_start),
    .xbar_last          (xbar_last),
    .xbar_bytes_valid   (xbar_bytes_valid),
    .xbar_data          (xbar_data),
    .fwd_count          (fwd_count),
    .drop_count         (drop_count)
  );

  always #5 fabric_clk = ~fabric_clk;

  int cyc = 0;
  always @(posedge fabric_clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------- monitor
  typedef struct packed {
    logic        s;
    logic        l;
    logic [3:0]  b;
    logic [63:0] d;
  } beat_t;

  beat_t q_beats[$];
  int n_pop = 0, n_fwd = 0, n_drop = 0, n_req = 0, n_lookup = 0;
  int cyc_pop = -1, cyc_drop = -1;

  // Record egress beats and event pulses mid-cycle.
  always @(negedge fabric_clk) begin
    if (xbar_valid) q_beats.push_back({xbar_start, xbar_last, xbar_bytes_valid, xbar_data});
    if (rx_pop)     begin n_pop++;  cyc_pop  = cyc; end
    if (drop_count) begin n_drop++; cyc_drop = cyc; end
    if (fwd_count)  n_fwd++;
    if (xbar_req)   n_req++;
    if (lookup_en)  n_lookup++;
  end

  int s_pop, s_fwd, s_drop, s_req, s_lookup;
  task automatic snap();
    s_pop = n_pop; s_fwd = n_fwd; s_drop = n_drop; s_req = n_req; s_lookup = n_lookup;
  endtask

  function automatic logic [63:0] pat(input int id, input int i);
    return {16'(id), 32'hC0DE_F00D, 16'(i)};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic present(input logic [47:0] mac, input logic [11:0] vlan, input int len);
    rx_frame_valid   = 1'b1;
    rx_frame_dst_mac = mac;
    rx_frame_vlan    = vlan;
    rx_frame_len     = 11'(len);
  endtask

  task automatic wait_lookup(output int c);
    int n = 0;
    while (lookup_en !== 1'b1 && n < c_WAIT_MAX) begin @(negedge fabric_clk); n++; end
    if (lookup_en !== 1'b1) check_value("lookup_en wait", 64'd0, 64'd1);
    c = cyc;
  endtask

  task automatic wait_pop(output int c);
    int n = 0;
    while (rx_pop !== 1'b1 && n < c_WAIT_MAX) begin @(negedge fabric_clk); n++; end
    if (rx_pop !== 1'b1) check_value("rx_pop wait", 64'd0, 64'd1);
    c = cyc;
  endtask

  task automatic do_lookup(input int delay, input logic [c_NUM_PORTS-1:0] mask);
    repeat (delay) @(negedge fabric_clk);
    lookup_done      = 1'b1;
    lookup_port_mask = mask;
    @(negedge fabric_clk);
    lookup_done      = 1'b0;
    lookup_port_mask = '0;
  endtask

  task automatic do_grant(input string tag, input int delay, input logic [c_NUM_PORTS-1:0] exp_mask);
    int n = 0;
    while (xbar_req !== 1'b1 && n < c_WAIT_MAX) begin @(negedge fabric_clk); n++; end
    check_value({tag, " xbar_req"}, 64'(xbar_req), 64'd1);
    check_value({tag, " port_mask"}, 64'(xbar_port_mask), 64'(exp_mask));
    repeat (delay) @(negedge fabric_clk);
    xbar_grant = 1'b1;
    @(negedge fabric_clk);
    xbar_grant = 1'b0;
    check_value({tag, " req after grant"}, 64'(xbar_req), 64'd0);
    check_value({tag, " rx_fwd_en"}, 64'(rx_fwd_en), 64'd1);
  endtask

  task automatic drive_beats(input int id, input int len, input int gap_at);
    int nb    = (len + 7) / 8;
    int lastb = (len % 8 == 0) ? 8 : len % 8;
    for (int i = 0; i < nb; i++) begin
      if (i == gap_at) begin
        rx_fwd_valid = 1'b0;
        @(negedge fabric_clk);
      end
      rx_fwd_valid       = 1'b1;
      rx_fwd_bytes_valid = 4'((i == nb - 1) ? lastb : 8);
      rx_fwd_data        = pat(id, i);
      @(negedge fabric_clk);
    end
    rx_fwd_valid = 1'b0;
  endtask

  task automatic verify_frame(input string tag, input int id, input int len);
    int    nb    = (len + 7) / 8;
    int    lastb = (len % 8 == 0) ? 8 : len % 8;
    int    nbad  = 0;
    beat_t bt;
    check_value({tag, " beats"}, 64'(q_beats.size()), 64'(nb));
    for (int i = 0; i < q_beats.size(); i++) begin
      bt = q_beats[i];
      if (bt.s !== (i == 0) || bt.l !== (i == nb - 1) ||
          bt.b !== 4'((i == nb - 1) ? lastb : 8) || bt.d !== pat(id, i)) nbad++;
    end
    check_value({tag, " bad beats"}, 64'(nbad), 64'd0);
    q_beats.delete();
  endtask

  // One complete forwarded frame; leaves the FIFO empty afterwards.
  task automatic fwd_frame(input string tag, input int id, input int len,
                           input logic [c_NUM_PORTS-1:0] lk_mask, input logic [c_NUM_PORTS-1:0] exp_mask,
                           input int lk_delay, input int gnt_delay, input int gap_at);
    int t, p;
    snap();
    present(48'h0200_0000_0000 | 48'(id), 12'(id + 100), len);
    wait_lookup(t);
    check_value({tag, " key mac"}, 64'(lookup_dst_mac), 64'(48'h0200_0000_0000 | 48'(id)));
    check_value({tag, " key vlan"}, 64'(lookup_vlan), 64'(id + 100));
    do_lookup(lk_delay, lk_mask);
    do_grant(tag, gnt_delay, exp_mask);
    drive_beats(id, len, gap_at);
    wait_pop(p);
    rx_frame_valid = 1'b0;
    @(negedge fabric_clk);
    @(negedge fabric_clk);
    verify_frame(tag, id, len);
    check_value({tag, " pops"}, 64'(n_pop - s_pop), 64'd1);
    check_value({tag, " fwd_count"}, 64'(n_fwd - s_fwd), 64'd1);
    check_value({tag, " drop_count"}, 64'(n_drop - s_drop), 64'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int t, p, pa;
    fabric_reset       = 1'b1;
    rx_frame_valid     = 1'b0;
    rx_frame_dst_mac   = '0;
    rx_frame_vlan      = '0;
    rx_frame_len       = '0;
    rx_fwd_valid       = 1'b0;
    rx_fwd_bytes_valid = '0;
    rx_fwd_data        = '0;
    lookup_done        = 1'b0;
    lookup_port_mask   = '0;
    xbar_grant         = 1'b0;

    repeat (2) @(negedge fabric_clk);
    check_value("reset ctl", 64'({rx_fwd_en, rx_pop, lookup_en, xbar_req, xbar_valid,
                                  xbar_start, xbar_last, fwd_count, drop_count}), 64'd0);
    check_value("reset mask", 64'(xbar_port_mask), 64'd0);
    check_value("reset data", xbar_data, 64'd0);
    fabric_reset = 1'b0;
    repeat (2) @(negedge fabric_clk);

    // 64-byte frame, mask 0x0006, grant two cycles after request.
    fwd_frame("f64", 1, 64, 14'h0006, 14'h0006, 1, 2, -1);
    // 61 bytes with a gap mid-frame: 8 beats, 5 bytes on the last.
    fwd_frame("f61", 2, 61, 14'h0006, 14'h0006, 0, 0, 3);
    // 8 bytes: single beat with start and last together.
    fwd_frame("f8", 3, 8, 14'h0010, 14'h0010, 2, 1, -1);
    // Own port plus port 5: source bit cleared from the request.
    fwd_frame("fsrc", 4, 24, 14'h0021, 14'h0020, 0, 0, -1);
    // lookup_done on the very cycle the timeout is reached still forwards.
    fwd_frame("fedge", 5, 16, 14'h0004, 14'h0004, c_TIMEOUT, 0, -1);

    // Destination set is only our own port: dropped, no crossbar request.
    snap();
    present(48'h0200_0000_0033, 12'd7, 64);
    wait_lookup(t);
    do_lookup(1, 14'h0001);
    wait_pop(p);
    rx_frame_valid = 1'b0;
    repeat (2) @(negedge fabric_clk);
    check_value("self req", 64'(n_req - s_req), 64'd0);
    check_value("self drop", 64'(n_drop - s_drop), 64'd1);
    check_value("self pop", 64'(n_pop - s_pop), 64'd1);
    check_value("self pop=drop cyc", 64'(cyc_pop), 64'(cyc_drop));

    // Lookup never answers: drop exactly TIMEOUT+1 cycles after lookup_en.
    snap();
    present(48'h0200_0000_0044, 12'd8, 40);
    wait_lookup(t);
    wait_pop(p);
    rx_frame_valid = 1'b0;
    check_value("tmo pop latency", 64'(p - t), 64'(c_TIMEOUT + 1));
    @(negedge fabric_clk);
    lookup_done      = 1'b1;
    lookup_port_mask = 14'h0006;
    repeat (2) @(negedge fabric_clk);
    lookup_done      = 1'b0;
    lookup_port_mask = '0;
    repeat (4) @(negedge fabric_clk);
    check_value("tmo drop", 64'(n_drop - s_drop), 64'd1);
    check_value("tmo late done req", 64'(n_req - s_req), 64'd0);
    check_value("tmo fwd", 64'(n_fwd - s_fwd), 64'd0);
    check_value("tmo lookups", 64'(n_lookup - s_lookup), 64'd1);

    // Zero-length frame: dropped without any lookup.
    snap();
    present(48'h0200_0000_0055, 12'd9, 0);
    wait_pop(p);
    rx_frame_valid = 1'b0;
    repeat (2) @(negedge fabric_clk);
    check_value("zlen lookups", 64'(n_lookup - s_lookup), 64'd0);
    check_value("zlen drop", 64'(n_drop - s_drop), 64'd1);

    // Back-to-back frames: 64 bytes then 1518 bytes (190 beats).
    snap();
    present(48'h0200_0000_000A, 12'd110, 64);
    wait_lookup(t);
    do_lookup(0, 14'h0002);
    do_grant("b2bA", 1, 14'h0002);
    drive_beats(10, 64, -1);
    wait_pop(pa);
    check_value("b2bA last at pop", 64'(xbar_last), 64'd1);
    present(48'h0200_0000_000B, 12'd111, 1518);
    @(negedge fabric_clk);
    verify_frame("b2bA", 10, 64);
    wait_lookup(t);
    check_value("b2b last->lookup gap", 64'(t - pa), 64'd3);
    check_value("b2bB key mac", 64'(lookup_dst_mac), 64'h0200_0000_000B);
    do_lookup(1, 14'h0300);
    do_grant("b2bB", 0, 14'h0300);
    drive_beats(11, 1518, 100);
    wait_pop(p);
    rx_frame_valid = 1'b0;
    repeat (2) @(negedge fabric_clk);
    verify_frame("b2bB", 11, 1518);
    check_value("b2b fwd", 64'(n_fwd - s_fwd), 64'd2);

    // Reset during FWD on the third beat.
    present(48'h0200_0000_000C, 12'd112, 64);
    wait_lookup(t);
    do_lookup(0, 14'h0008);
    do_grant("rst", 0, 14'h0008);
    for (int i = 0; i < 3; i++) begin
      rx_fwd_valid       = 1'b1;
      rx_fwd_bytes_valid = 4'd8;
      rx_fwd_data        = pat(12, i);
      @(negedge fabric_clk);
    end
    check_value("rst beat3 valid", 64'(xbar_valid), 64'd1);
    snap();
    fabric_reset   = 1'b1;
    rx_fwd_valid   = 1'b0;
    rx_frame_valid = 1'b0;
    #1;
    check_value("rst mid ctl", 64'({rx_fwd_en, rx_pop, lookup_en, xbar_req, xbar_valid,
                                    xbar_start, xbar_last, fwd_count, drop_count}), 64'd0);
    check_value("rst mid data", xbar_data, 64'd0);
    check_value("rst mid bytes", 64'(xbar_bytes_valid), 64'd0);
    check_value("rst mid key", 64'(lookup_dst_mac), 64'd0);
    repeat (2) @(negedge fabric_clk);
    fabric_reset = 1'b0;
    @(negedge fabric_clk);
    check_value("rst no pop", 64'(n_pop - s_pop), 64'd0);
    q_beats.delete();
    fwd_frame("post", 13, 8, 14'h0040, 14'h0040, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
